// File: rtl/vga_scroll_addr_gen_pkg.sv
// Shared types and default geometry for the scrolling/split VGA address generator.
package vga_scroll_addr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SCROLL     = 2'd1,
    ST_SPLIT      = 2'd2,
    ST_SPLIT_HOLD = 2'd3
  } state_e;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam int DEF_IMG_W    = 320;
  localparam int DEF_IMG_H    = 240;
  localparam int DEF_SCALE_SH = 1;

endpackage

// File: rtl/vga_scroll_addr_gen_wrap_step.sv
// Modular add/subtract of one step; valid while step < limit and value < limit.
module wrap_step #(
  parameter int W = 12
) (
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] step_i,
  input  logic         up_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] value_o
);

  logic [W:0] sum, diff;

  always_comb begin
    sum  = {1'b0, value_i} + {1'b0, step_i};
    diff = {1'b0, value_i} + {1'b0, limit_i} - {1'b0, step_i};
    if (up_i)
      value_o = (sum >= {1'b0, limit_i}) ? W'(sum - {1'b0, limit_i}) : W'(sum);
    else
      value_o = (value_i >= step_i) ? (value_i - step_i) : W'(diff);
  end

endmodule

// File: rtl/vga_scroll_addr_gen.sv
// Frame-stepped scroll/split controller producing a registered image-memory address per display pixel.
module vga_scroll_addr_gen
  import vga_scroll_addr_gen_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int SCALE_SH = DEF_SCALE_SH,
  parameter int STEP     = 1,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              shift,
  input  logic              split,
  input  logic [1:0]        dir,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              show_black,
  output logic [1:0]        mode
);

  // Wide enough for any 10-bit coordinate plus an offset below the image size.
  localparam int CW = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H + 1) + 1024) + 1;

  localparam logic [CW-1:0]     W_C     = CW'(IMG_W);
  localparam logic [CW-1:0]     H_C     = CW'(IMG_H);
  localparam logic [CW-1:0]     HALF_C  = CW'(IMG_W / 2);
  localparam logic [CW-1:0]     STEP_C  = CW'(STEP);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  state_e            state_q, state_d;
  logic [CW-1:0]     off_x_q, off_x_d;
  logic [CW-1:0]     off_y_q, off_y_d;
  logic [CW-1:0]     split_off_q, split_off_d;
  logic [CW-1:0]     off_x_step, off_y_step, split_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              blk_q, blk_d;

  logic [CW-1:0]     x, y, xs, ys;

  wrap_step #(.W(CW)) u_wrap_x (
    .value_i (off_x_q),
    .step_i  (STEP_C),
    .up_i    (dir == DIR_LEFT),
    .limit_i (W_C),
    .value_o (off_x_step)
  );

  wrap_step #(.W(CW)) u_wrap_y (
    .value_i (off_y_q),
    .step_i  (STEP_C),
    .up_i    (dir == DIR_UP),
    .limit_i (H_C),
    .value_o (off_y_step)
  );

  assign split_inc = split_off_q + STEP_C;

  always_comb begin
    state_d     = state_q;
    off_x_d     = off_x_q;
    off_y_d     = off_y_q;
    split_off_d = split_off_q;
    if (frame_start) begin
      case (state_q)
        ST_IDLE, ST_SCROLL: begin
          if (split) begin
            state_d     = ST_SPLIT;
            split_off_d = '0;
          end else if (shift) begin
            state_d = ST_SCROLL;
            if (!dir[1]) off_x_d = off_x_step;
            else         off_y_d = off_y_step;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SPLIT: begin
          if (!split) begin
            state_d     = ST_IDLE;
            split_off_d = '0;
          end else if (split_inc >= H_C) begin
            state_d     = ST_SPLIT_HOLD;
            split_off_d = H_C;
          end else begin
            split_off_d = split_inc;
          end
        end
        default: begin
          if (!split) begin
            state_d     = ST_IDLE;
            split_off_d = '0;
          end
        end
      endcase
    end
  end

  // Address path sees the registered state/offsets, so a frame_start edge
  // only affects pixels sampled from the following cycle onward.
  always_comb begin
    x     = CW'(h_cnt >> SCALE_SH);
    y     = CW'(v_cnt >> SCALE_SH);
    blk_d = (x >= W_C) || (y >= H_C);
    xs    = x + off_x_q;
    if (xs >= W_C) xs = xs - W_C;
    ys = '0;
    if (state_q == ST_IDLE || state_q == ST_SCROLL) begin
      ys = y + off_y_q;
      if (ys >= H_C) ys = ys - H_C;
    end else if (x < HALF_C) begin
      ys = y + split_off_q;
      if (ys >= H_C) blk_d = 1'b1;
    end else begin
      if (y < split_off_q) blk_d = 1'b1;
      ys = y - split_off_q;
    end
    addr_d = blk_d ? '0 : (ADDR_W'(ys) * IMG_W_A + ADDR_W'(xs));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      off_x_q     <= '0;
      off_y_q     <= '0;
      split_off_q <= '0;
      addr_q      <= '0;
      blk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_x_q     <= off_x_d;
      off_y_q     <= off_y_d;
      split_off_q <= split_off_d;
      addr_q      <= addr_d;
      blk_q       <= blk_d;
    end
  end

  assign pixel_addr = addr_q;
  assign show_black = blk_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_vga_scroll_addr_gen.sv
// Directed checks of scroll, wrap, split and reset behaviour at default geometry.
module tb_vga_scroll_addr_gen;

  logic        clk = 1'b0;
  logic        rst, frame_start, shift, split;
  logic [9:0]  h_cnt, v_cnt;
  logic [1:0]  dir;
  logic [16:0] pixel_addr;
  logic        show_black;
  logic [1:0]  mode;

  int errors = 0;
  int checks = 0;

  vga_scroll_addr_gen dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .shift       (shift),
    .split       (split),
    .dir         (dir),
    .pixel_addr  (pixel_addr),
    .show_black  (show_black),
    .mode        (mode)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    frame_start = 1'b1;
    repeat (n) tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic px(input int h, input int v);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    tick();
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; shift = 1'b0; split = 1'b0; dir = 2'b00;
    h_cnt = 10'd100; v_cnt = 10'd50;
    tick();
    check("rst_mode", 32'(mode), 0);
    check("rst_addr", 32'(pixel_addr), 0);
    check("rst_black", 32'(show_black), 0);

    rst = 1'b0;
    px(100, 50);
    check("idle_addr", 32'(pixel_addr), 8050);
    check("idle_black", 32'(show_black), 0);
    check("idle_mode", 32'(mode), 0);

    // three back-to-back pulses each step once
    shift = 1'b1; dir = 2'b00;
    pulse(3);
    px(100, 50);
    check("left3_mode", 32'(mode), 1);
    check("left3_addr", 32'(pixel_addr), 8053);

    shift = 1'b0;
    pulse(1);
    px(100, 50);
    check("pause_mode", 32'(mode), 0);
    check("pause_addr", 32'(pixel_addr), 8053);

    do_reset();
    shift = 1'b1; dir = 2'b01;
    pulse(1);
    px(10, 50);
    check("right_wrap_addr", 32'(pixel_addr), 8004);
    check("right_wrap_mode", 32'(mode), 1);

    do_reset();
    dir = 2'b10;
    pulse(1);
    px(2, 478);
    check("up_wrap_addr", 32'(pixel_addr), 1);
    check("up_wrap_black", 32'(show_black), 0);
    dir = 2'b11;
    pulse(2);
    px(0, 0);
    check("down_wrap_addr", 32'(pixel_addr), 76480);

    // split wins over an active shift
    do_reset();
    split = 1'b1; shift = 1'b1; dir = 2'b00;
    pulse(11);
    px(100, 50);
    check("split_mode", 32'(mode), 2);
    check("split_left_addr", 32'(pixel_addr), 11250);
    check("split_left_black", 32'(show_black), 0);
    px(400, 10);
    check("split_right_black", 32'(show_black), 1);
    check("split_right_addr0", 32'(pixel_addr), 0);
    px(400, 100);
    check("split_right_addr", 32'(pixel_addr), 13000);

    pulse(229);
    px(0, 0);
    check("split239_mode", 32'(mode), 2);
    check("split239_addr", 32'(pixel_addr), 76480);
    pulse(11);
    px(100, 50);
    check("hold_mode", 32'(mode), 3);
    check("hold_left_black", 32'(show_black), 1);
    check("hold_left_addr", 32'(pixel_addr), 0);
    px(400, 400);
    check("hold_right_black", 32'(show_black), 1);

    split = 1'b0; shift = 1'b0;
    pulse(1);
    px(100, 50);
    check("unsplit_mode", 32'(mode), 0);
    check("unsplit_addr", 32'(pixel_addr), 8050);

    // reset overrides a coincident frame_start mid-scroll
    shift = 1'b1; dir = 2'b00;
    pulse(5);
    px(100, 50);
    check("pre_rst_addr", 32'(pixel_addr), 8055);
    rst = 1'b1; frame_start = 1'b1;
    tick();
    rst = 1'b0; frame_start = 1'b0;
    check("rst_fs_mode", 32'(mode), 0);
    px(100, 50);
    check("post_rst_addr", 32'(pixel_addr), 8050);
    px(640, 50);
    check("edge_black", 32'(show_black), 1);
    check("edge_addr", 32'(pixel_addr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
